reorder_buffer: RTL
===================

Name: reorder_buffer

Overview:
Parametrised circular reorder buffer for the Tomasulo core. It allocates one tagged entry per issued instruction, snoops NUM_CDB common-data-bus channels for results, and retires entries strictly in program order onto the register-file commit bus. It also serves two operand-lookup ports so issue logic can read renamed values, including a same-cycle CDB bypass. It supports a full synchronous flush.

Parameters:
DEPTH, 8, number of entries; power of two, >=2; TAG_W = $clog2(DEPTH)
XLEN, 32, result data width
REG_AW, 5, architectural register index width
NUM_CDB, 6, CDB channels (3 add, 2 mul, 1 load/store)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  discard all entries
alloc_valid  in  1  issue requests an entry
alloc_rd  in  REG_AW  destination register; 0 = no writeback
alloc_ready  out  1  entry available (count < DEPTH)
alloc_tag  out  TAG_W  tag granted (= tail pointer)
cdb_valid  in  NUM_CDB  per-channel result valid
cdb_tag  in  NUM_CDB*TAG_W  flattened tags, channel i at [i*TAG_W +: TAG_W]
cdb_data  in  NUM_CDB*XLEN  flattened results
lk_tag_a / lk_tag_b  in  TAG_W  lookup tags
lk_ready_a / lk_ready_b  out  1  entry result available
lk_data_a / lk_data_b  out  XLEN  entry result
commit_wen  out  1  register-file write strobe
commit_idx  out  REG_AW  register written
commit_data  out  XLEN  value written
commit_tag  out  TAG_W  tag retired this cycle
empty  out  1  count == 0

Behaviour:
- Reset: head, tail and count are 0. All entry busy/ready bits are 0. commit_wen=0, commit_idx=0, commit_data=0, commit_tag=0. alloc_ready=1, empty=1.
- Entry state: busy, ready, rd, data.
- Allocate: fires when alloc_valid && alloc_ready. Sets entry[tail] to busy=1, ready=0, rd=alloc_rd; tail increments mod DEPTH. alloc_ready is derived from the registered count only; a commit in the same cycle does not free space for allocation.
- CDB write: for each busy && !ready entry, the lowest-index channel with cdb_valid and a matching tag sets ready=1 and data. Matches on non-busy or already-ready entries are ignored. A CDB hit on the tag being allocated in the same cycle is ignored.
- Commit (registered):
  - Condition: entry[head] busy && ready at a clock edge.
  - Effect: the entry is freed and head increments.
  - Outputs: commit_idx=rd, commit_data=data, commit_tag=head are updated, and commit_wen is set to (rd!=0).
  - Otherwise commit_wen=0 next cycle; idx/data/tag hold.
  - At most one retire per cycle.
  - Latency: a result on the CDB at edge N gives commit_wen high after edge N+1 if the entry is the head.
- Count: +1 on allocate, -1 on retire, unchanged if both occur. It never exceeds DEPTH or goes below 0.
- Lookup (combinational):
  - If the entry is busy && ready: lk_ready=1 and lk_data=entry data.
  - Else if a CDB channel carries that tag this cycle and the entry is busy: lk_ready=1 and lk_data=CDB data, with the lowest channel winning.
  - Else lk_ready=0 and lk_data=0.
- Flush: synchronous and highest priority. Clears all busy/ready bits and sets head=tail=count=0. commit_wen=0 next cycle. Alloc, CDB and commit in the flush cycle are discarded.
- Wrap-around: pointers wrap DEPTH-1 -> 0. With count==DEPTH, head==tail; the full/empty state is disambiguated by count.
- Reset asserted mid-operation returns everything to the reset values immediately.

Decomposition:
- Shared package tomasulo_pkg holds:
  - XLEN and REG_AW defaults
  - the rob_entry_t struct (busy, ready, rd, data)
  - the CDB channel index constants CDB_ADD1..CDB_LS
- One sub-module, cdb_tag_match: a combinational lowest-index priority match of one tag against all NUM_CDB channels, returning hit and data. It is instantiated per entry and per lookup port.

Test Plan:
1. Reset, then allocate 8 entries (rd=1..8) -> alloc_tag 0..7. alloc_ready=0 after the 8th; a 9th alloc_valid is ignored.
2. CDB ch3 tag=0 data=0xDEADBEEF at edge N -> after N+1, commit_wen=1, commit_idx=1, commit_data=0xDEADBEEF, commit_tag=0. alloc_ready=1.
3. Out-of-order completion: tags 2 then 1 complete before tag 0 -> commits appear in order 0,1,2 on consecutive cycles, one per cycle.
4. lk_tag_a=5 while CDB ch0 broadcasts tag5=0x55 -> lk_ready_a=1, lk_data_a=0x55 in the same cycle. The registered value is visible the next cycle.
5. Entry with rd=0 completes -> retires and head advances, but commit_wen=0.
6. Six entries busy and flush asserted together with alloc_valid and a CDB hit -> next cycle empty=1, alloc_tag=0, commit_wen=0. Wrap test: 20 alloc/commit cycles pass pointers through 7->0 with correct tags.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core types: datapath defaults, ROB entry layout and CDB channel map.
package tomasulo_pkg;

    // Datapath defaults; rob_entry_t is sized from these.
    localparam int ROB_XLEN   = 32;
    localparam int ROB_REG_AW = 5;

    // Common data bus channel assignment (lower index wins on tag conflicts).
    localparam int CDB_ADD1     = 0;
    localparam int CDB_ADD2     = 1;
    localparam int CDB_ADD3     = 2;
    localparam int CDB_MUL1     = 3;
    localparam int CDB_MUL2     = 4;
    localparam int CDB_LS       = 5;
    localparam int CDB_CHANNELS = 6;

    // One reorder-buffer slot. rd == 0 means the instruction has no writeback.
    typedef struct packed {
        logic                  busy;
        logic                  ready;
        logic [ROB_REG_AW-1:0] rd;
        logic [ROB_XLEN-1:0]   data;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue / CDB / lookup / commit signal bundle of the reorder buffer.
// master = issue + execution side, slave = reorder buffer.
interface reorder_buffer_if
    import tomasulo_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int XLEN    = ROB_XLEN,
    parameter int REG_AW  = ROB_REG_AW,
    parameter int NUM_CDB = CDB_CHANNELS
);
    localparam int TAG_W = $clog2(DEPTH);

    logic                       flush;

    // allocation
    logic                       alloc_valid;
    logic [REG_AW-1:0]          alloc_rd;
    logic                       alloc_ready;
    logic [TAG_W-1:0]           alloc_tag;

    // common data bus, channel i at [i*W +: W]
    logic [NUM_CDB-1:0]         cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]   cdb_tag;
    logic [NUM_CDB*XLEN-1:0]    cdb_data;

    // operand lookup ports
    logic [TAG_W-1:0]           lk_tag_a;
    logic [TAG_W-1:0]           lk_tag_b;
    logic                       lk_ready_a;
    logic                       lk_ready_b;
    logic [XLEN-1:0]            lk_data_a;
    logic [XLEN-1:0]            lk_data_b;

    // register-file commit
    logic                       commit_wen;
    logic [REG_AW-1:0]          commit_idx;
    logic [XLEN-1:0]            commit_data;
    logic [TAG_W-1:0]           commit_tag;
    logic                       empty;

    modport master (
        output flush, alloc_valid, alloc_rd,
        output cdb_valid, cdb_tag, cdb_data,
        output lk_tag_a, lk_tag_b,
        input  alloc_ready, alloc_tag,
        input  lk_ready_a, lk_ready_b, lk_data_a, lk_data_b,
        input  commit_wen, commit_idx, commit_data, commit_tag, empty
    );

    modport slave (
        input  flush, alloc_valid, alloc_rd,
        input  cdb_valid, cdb_tag, cdb_data,
        input  lk_tag_a, lk_tag_b,
        output alloc_ready, alloc_tag,
        output lk_ready_a, lk_ready_b, lk_data_a, lk_data_b,
        output commit_wen, commit_idx, commit_data, commit_tag, empty
    );

endinterface

// File: rtl/cdb_tag_match.sv
// Compares one tag against every CDB channel; the lowest-index matching
// valid channel supplies the data.
module cdb_tag_match #(
    parameter int NUM_CDB = 6,
    parameter int TAG_W   = 3,
    parameter int XLEN    = 32
)(
    input  logic [TAG_W-1:0]         tag,
    input  logic [NUM_CDB-1:0]       cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]  cdb_data,
    output logic                     hit,
    output logic [XLEN-1:0]          data
);

    // Scan high to low so the lowest matching channel is the last writer.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = NUM_CDB - 1; i >= 0; i--) begin
            if (cdb_valid[i] && (cdb_tag[i*TAG_W +: TAG_W] == tag)) begin
                hit  = 1'b1;
                data = cdb_data[i*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, CDB snoop, in-order retire
// onto the register-file commit bus, two operand lookup ports with CDB bypass.
// XLEN / REG_AW must stay equal to the package defaults that size rob_entry_t.
module reorder_buffer
    import tomasulo_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int XLEN    = ROB_XLEN,
    parameter int REG_AW  = ROB_REG_AW,
    parameter int NUM_CDB = CDB_CHANNELS
)(
    input  logic            clk,
    input  logic            rst_n,
    reorder_buffer_if.slave rob
);

    localparam int             TAG_W    = $clog2(DEPTH);
    localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

    rob_entry_t          entries_q [DEPTH];
    rob_entry_t          entries_d [DEPTH];
    logic [TAG_W-1:0]    head_q, head_d;
    logic [TAG_W-1:0]    tail_q, tail_d;
    logic [TAG_W:0]      count_q, count_d;

    logic                commit_wen_q,  commit_wen_d;
    logic [REG_AW-1:0]   commit_idx_q,  commit_idx_d;
    logic [XLEN-1:0]     commit_data_q, commit_data_d;
    logic [TAG_W-1:0]    commit_tag_q,  commit_tag_d;

    logic [DEPTH-1:0]             ent_hit;
    logic [DEPTH-1:0][XLEN-1:0]   ent_data;
    logic                         lk_hit_a, lk_hit_b;
    logic [XLEN-1:0]              lk_cdb_a, lk_cdb_b;

    logic       alloc_ready;
    logic       alloc_fire;
    logic       retire;
    rob_entry_t head_ent;

    // Space check looks only at the registered count, so a same-cycle
    // retire never makes room for an allocation.
    assign alloc_ready = (count_q != FULL_CNT);
    assign alloc_fire  = rob.alloc_valid && alloc_ready;
    assign head_ent    = entries_q[head_q];
    assign retire      = head_ent.busy && head_ent.ready;

    // One CDB matcher per entry; each entry's tag is its own index.
    for (genvar e = 0; e < DEPTH; e++) begin : g_ent
        cdb_tag_match #(.NUM_CDB(NUM_CDB), .TAG_W(TAG_W), .XLEN(XLEN)) u_match (
            .tag       (TAG_W'(e)),
            .cdb_valid (rob.cdb_valid),
            .cdb_tag   (rob.cdb_tag),
            .cdb_data  (rob.cdb_data),
            .hit       (ent_hit[e]),
            .data      (ent_data[e])
        );
    end

    cdb_tag_match #(.NUM_CDB(NUM_CDB), .TAG_W(TAG_W), .XLEN(XLEN)) u_lk_a (
        .tag       (rob.lk_tag_a),
        .cdb_valid (rob.cdb_valid),
        .cdb_tag   (rob.cdb_tag),
        .cdb_data  (rob.cdb_data),
        .hit       (lk_hit_a),
        .data      (lk_cdb_a)
    );

    cdb_tag_match #(.NUM_CDB(NUM_CDB), .TAG_W(TAG_W), .XLEN(XLEN)) u_lk_b (
        .tag       (rob.lk_tag_b),
        .cdb_valid (rob.cdb_valid),
        .cdb_tag   (rob.cdb_tag),
        .cdb_data  (rob.cdb_data),
        .hit       (lk_hit_b),
        .data      (lk_cdb_b)
    );

    // Stored result first, then same-cycle CDB bypass; free entries never answer.
    function automatic logic [XLEN:0] lookup(input rob_entry_t ent,
                                             input logic hit,
                                             input logic [XLEN-1:0] cdb_d);
        if (ent.busy && ent.ready) return {1'b1, ent.data};
        if (ent.busy && hit)       return {1'b1, cdb_d};
        return '0;
    endfunction

    assign {rob.lk_ready_a, rob.lk_data_a} = lookup(entries_q[rob.lk_tag_a], lk_hit_a, lk_cdb_a);
    assign {rob.lk_ready_b, rob.lk_data_b} = lookup(entries_q[rob.lk_tag_b], lk_hit_b, lk_cdb_b);

    // Next-state: CDB capture, head retire, tail allocate, count; flush overrides all.
    always_comb begin
        entries_d     = entries_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        commit_wen_d  = 1'b0;
        commit_idx_d  = commit_idx_q;
        commit_data_d = commit_data_q;
        commit_tag_d  = commit_tag_q;

        // Only waiting entries capture; the slot being allocated is not busy
        // yet, so a hit on its tag falls out here too.
        for (int e = 0; e < DEPTH; e++) begin
            if (entries_q[e].busy && !entries_q[e].ready && ent_hit[e]) begin
                entries_d[e].ready = 1'b1;
                entries_d[e].data  = ent_data[e];
            end
        end

        if (retire) begin
            entries_d[head_q].busy  = 1'b0;
            entries_d[head_q].ready = 1'b0;
            head_d        = head_q + 1'b1;
            commit_wen_d  = (head_ent.rd != '0);
            commit_idx_d  = head_ent.rd;
            commit_data_d = head_ent.data;
            commit_tag_d  = head_q;
        end

        // tail == head with a busy head only when full, where alloc is blocked.
        if (alloc_fire) begin
            entries_d[tail_q] = '{busy: 1'b1, ready: 1'b0, rd: rob.alloc_rd, data: '0};
            tail_d = tail_q + 1'b1;
        end

        case ({alloc_fire, retire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Commit bus keeps its last idx/data/tag; only the strobe drops.
        if (rob.flush) begin
            for (int e = 0; e < DEPTH; e++) begin
                entries_d[e].busy  = 1'b0;
                entries_d[e].ready = 1'b0;
            end
            head_d        = '0;
            tail_d        = '0;
            count_d       = '0;
            commit_wen_d  = 1'b0;
            commit_idx_d  = commit_idx_q;
            commit_data_d = commit_data_q;
            commit_tag_d  = commit_tag_q;
        end
    end

    // State and commit-bus registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < DEPTH; e++) entries_q[e] <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            commit_wen_q  <= 1'b0;
            commit_idx_q  <= '0;
            commit_data_q <= '0;
            commit_tag_q  <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) entries_q[e] <= entries_d[e];
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            commit_wen_q  <= commit_wen_d;
            commit_idx_q  <= commit_idx_d;
            commit_data_q <= commit_data_d;
            commit_tag_q  <= commit_tag_d;
        end
    end

    assign rob.alloc_ready = alloc_ready;
    assign rob.alloc_tag   = tail_q;
    assign rob.empty       = (count_q == '0);
    assign rob.commit_wen  = commit_wen_q;
    assign rob.commit_idx  = commit_idx_q;
    assign rob.commit_data = commit_data_q;
    assign rob.commit_tag  = commit_tag_q;

endmodule
